// File: rtl/updown_dir_ctrl.sv
// Count-direction controller: synchronises and debounces a push-button and toggles
// up_down once per press. Optional auto-reverse at the count limits: UPDOWN_AUTO_REVERSE_EN.
module updown_dir_ctrl #(
    parameter int unsigned CNT_W           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_raw,
    input  logic [CNT_W-1:0] count,
    output logic             up_down,
    output logic             dir_changed,
    output logic             btn_level
);

    localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        HELD
    } state_t;

    state_t          state;
    logic            sync1;
    logic            btn_sync;
    logic [DB_W-1:0] db_cnt;
    logic            press;
    logic            flip;

    // Two-flop synchroniser followed by a run-length debouncer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            btn_sync  <= 1'b0;
            db_cnt    <= '0;
            btn_level <= 1'b0;
        end else begin
            sync1    <= btn_raw;
            btn_sync <= sync1;
            if (btn_sync != btn_level) begin
                if (db_cnt == DB_LAST) begin
                    btn_level <= btn_sync;
                    db_cnt    <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign press = (state == IDLE) && btn_level;

`ifdef UPDOWN_AUTO_REVERSE_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_MAX - CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic at_turn;
    logic wrap_risk;

    // A turn and a press on the same edge flip once; a press that would wrap is dropped.
    always_comb begin
        at_turn   = (up_down && (count == CNT_TOP)) || (!up_down && (count == CNT_ONE));
        wrap_risk = (!up_down && (count == CNT_MAX)) || (up_down && (count == '0));
        flip      = at_turn || (press && !wrap_risk);
    end
`else
    logic unused_count;
    assign unused_count = ^count;

    always_comb begin
        flip = press;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            up_down     <= 1'b1;
            dir_changed <= 1'b0;
        end else begin
            case (state)
                IDLE: if (btn_level)  state <= HELD;
                HELD: if (!btn_level) state <= IDLE;
            endcase
            up_down     <= up_down ^ flip;
            dir_changed <= flip;
        end
    end

endmodule

// File: tb/tb_updown_dir_ctrl.sv
// Self-checking bench for updown_dir_ctrl: queue scoreboard fed by a behavioural
// model, plus directed timing checks; honours UPDOWN_AUTO_REVERSE_EN.
module tb_updown_dir_ctrl;

    localparam int unsigned CNT_W = 3;
    localparam int unsigned DC    = 4;
    localparam int unsigned MAXV  = (1 << CNT_W) - 1;
`ifdef UPDOWN_AUTO_REVERSE_EN
    localparam int unsigned IDLE_EDGES = 6;
`else
    localparam int unsigned IDLE_EDGES = 20;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             btn_raw;
    logic [CNT_W-1:0] count;
    logic             up_down;
    logic             dir_changed;
    logic             btn_level;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    updown_dir_ctrl #(
        .CNT_W(CNT_W),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_raw(btn_raw),
        .count(count),
        .up_down(up_down),
        .dir_changed(dir_changed),
        .btn_level(btn_level)
    );

    // Downstream up/down counter, wraps naturally.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else        count <= up_down ? count + CNT_W'(1) : count - CNT_W'(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model + scoreboard ----------------
    typedef struct packed {
        logic ud;
        logic dir;
        logic lvl;
    } exp_t;

    exp_t sb_q[$];
    bit   raw_q[$];
    bit   sync_q[$];
    bit   m_level   = 1'b0;
    bit   m_level_d = 1'b0;
    bit   m_ud      = 1'b1;

    task automatic model_reset();
        raw_q.delete();
        sync_q.delete();
        m_level   = 1'b0;
        m_level_d = 1'b0;
        m_ud      = 1'b1;
    endtask

    always @(negedge rst_n) begin
        sb_q.delete();
        model_reset();
    end

    always @(posedge clk) begin : model
        bit s, new_level, ev, flip;
        int unsigned dis;
        if (!rst_n) begin
            model_reset();
            sb_q.push_back(exp_t'{1'b1, 1'b0, 1'b0});
        end else begin
            // the debouncer sees the raw level sampled two edges earlier
            s = (raw_q.size() >= 2) ? raw_q[raw_q.size() - 2] : 1'b0;
            raw_q.push_back(btn_raw);
            if (raw_q.size() > 4) void'(raw_q.pop_front());
            sync_q.push_back(s);
            if (sync_q.size() > DC) void'(sync_q.pop_front());
            new_level = m_level;
            if (sync_q.size() == DC) begin
                dis = 0;
                foreach (sync_q[i]) if (sync_q[i] != m_level) dis++;
                if (dis == DC) new_level = !m_level;
            end
            ev = m_level && !m_level_d;
`ifdef UPDOWN_AUTO_REVERSE_EN
            flip = (m_ud && int'(count) == MAXV - 1) || (!m_ud && int'(count) == 1)
                || (ev && !((!m_ud && int'(count) == MAXV) || (m_ud && int'(count) == 0)));
`else
            flip = ev;
`endif
            m_level_d = m_level;
            m_level   = new_level;
            if (flip) m_ud = !m_ud;
            sb_q.push_back(exp_t'{m_ud, flip, m_level});
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_up_down", up_down, e.ud);
            chk("sb_dir_changed", dir_changed, e.dir);
            chk("sb_btn_level", btn_level, e.lvl);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    function automatic int unsigned tri_wave(input int unsigned n);
        int unsigned p;
        p = n % (2 * MAXV);
        return (p <= MAXV) ? p : 2 * MAXV - p;
    endfunction

    initial begin
        bit pat[5];
        bit lvl;
        int unsigned len;
        rst_n   = 1'b1;
        btn_raw = 1'b0;
        #1 rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;

        // idle after reset
        for (int unsigned i = 0; i < IDLE_EDGES; i++) begin
            step(1);
            chk("idle_up_down", up_down, 1);
            chk("idle_dir_changed", dir_changed, 0);
            chk("idle_btn_level", btn_level, 0);
        end

        // clean press of 20 cycles; event lands with count 6, so both builds flip once at edge 7
        do_reset();
        btn_raw = 1'b1;
        step(5);
        chk("press_lvl_e5", btn_level, 0);
        step(1);
        chk("press_lvl_e6", btn_level, 1);
        chk("press_ud_e6", up_down, 1);
        step(1);
        chk("press_ud_e7", up_down, 0);
        chk("press_dir_e7", dir_changed, 1);
        step(1);
        chk("press_dir_e8", dir_changed, 0);
        step(12);
        btn_raw = 1'b0;
`ifndef UPDOWN_AUTO_REVERSE_EN
        for (int unsigned i = 0; i < 12; i++) begin
            step(1);
            chk("release_ud", up_down, 0);
            chk("release_dir", dir_changed, 0);
        end
        chk("release_lvl", btn_level, 0);
`else
        step(12);
`endif

        // bounce 1,0,1,1,0 then steady 1
        do_reset();
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        foreach (pat[i]) begin
            btn_raw = pat[i];
            step(1);
        end
        btn_raw = 1'b1;
        step(5);
        chk("bounce_lvl_e5", btn_level, 0);
        step(1);
        chk("bounce_lvl_e6", btn_level, 1);
`ifndef UPDOWN_AUTO_REVERSE_EN
        chk("bounce_ud_e6", up_down, 1);
        step(1);
        chk("bounce_ud_e7", up_down, 0);
        chk("bounce_dir_e7", dir_changed, 1);
`endif
        step(10);
        btn_raw = 1'b0;
        step(10);

        // 3-cycle glitches only
        do_reset();
        repeat (5) begin
            btn_raw = 1'b1;
            step(3);
            btn_raw = 1'b0;
            step(3);
            chk("glitch_lvl", btn_level, 0);
`ifndef UPDOWN_AUTO_REVERSE_EN
            chk("glitch_ud", up_down, 1);
`endif
        end
        step(6);

        // free-running count sequence
        do_reset();
        for (int unsigned n = 1; n <= 40; n++) begin
            step(1);
`ifdef UPDOWN_AUTO_REVERSE_EN
            chk("freerun_count", count, tri_wave(n));
`else
            chk("freerun_count", count, n % (MAXV + 1));
`endif
        end

        // press event landing at edge 8, where count = 7
        do_reset();
        step(1);
        btn_raw = 1'b1;
        step(6);
`ifdef UPDOWN_AUTO_REVERSE_EN
        chk("supp_ud_e7", up_down, 0);
        chk("supp_dir_e7", dir_changed, 1);
        step(1);
        chk("supp_ud_e8", up_down, 0);
        chk("supp_dir_e8", dir_changed, 0);
`else
        chk("supp_ud_e7", up_down, 1);
        step(1);
        chk("supp_ud_e8", up_down, 0);
        chk("supp_dir_e8", dir_changed, 1);
`endif
        step(8);
        btn_raw = 1'b0;
        step(10);

        // reset mid-debounce with the button held
        do_reset();
        btn_raw = 1'b1;
        step(3);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ud", up_down, 1);
        chk("midrst_dir", dir_changed, 0);
        chk("midrst_lvl", btn_level, 0);
        step(2);
        rst_n = 1'b1;
        step(6);
        chk("afterrst_ud_e6", up_down, 1);
        chk("afterrst_lvl_e6", btn_level, 1);
        step(1);
        chk("afterrst_ud_e7", up_down, 0);
        chk("afterrst_dir_e7", dir_changed, 1);
        step(1);
        chk("afterrst_dir_e8", dir_changed, 0);
        btn_raw = 1'b0;
        step(10);

        // randomised bouncy runs, checked by the scoreboard
        do_reset();
        repeat (80) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 14);
            repeat (len) begin
                btn_raw = lvl;
                step(1);
            end
        end
        btn_raw = 1'b0;
        step(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_dir_ctrl.md
# updown_dir_ctrl

Direction controller that sits directly upstream of the 3-bit up/down counter and drives its `up_down` input. It synchronises and debounces a raw push-button, and toggles the count direction once per clean press. It also returns the counter's current value to optionally bounce the direction at the count limits, so the counter ping-pongs instead of wrapping.

## Interface
- `CNT_W`, default 3: width of the fed-back count; the limit is MAX = 2^CNT_W − 1.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples needed to accept a button level change; legal range ≥ 1.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `btn_raw`  input  1: raw, asynchronous, bouncy button; 1 = pressed.
- `count`  input  CNT_W: current counter register value, fed back from the downstream counter.
- `up_down`  output  1: direction to the counter; 1 = up, 0 = down.
- `dir_changed`  output  1: one-cycle pulse on every change of `up_down`.
- `btn_level`  output  1: debounced button level.

## Operation
- Reset values:
  - `up_down` = 1, so it matches counter reset 0 counting up.
  - `dir_changed` = 0 and `btn_level` = 0.
  - Both synchroniser flops = 0, debounce counter = 0, FSM = IDLE.
- Synchroniser: two flops, `btn_raw` → s1 → s2 (`btn_sync`).
- Debouncer:
  - Counter width is clog2(DEBOUNCE_CYCLES + 1).
  - If `btn_sync` ≠ `btn_level`: if the counter == DEBOUNCE_CYCLES − 1, then `btn_level` ← `btn_sync` and the counter ← 0; otherwise the counter increments.
  - If `btn_sync` == `btn_level`, the counter ← 0.
  - Any disagreeing run shorter than DEBOUNCE_CYCLES is discarded.
- FSM, two states:
  - IDLE: `btn_level` = 1 raises a press event and goes to HELD.
  - HELD: `btn_level` = 0 goes to IDLE. No event while held, so one toggle per press regardless of hold length.
- Press event: `up_down` ← ~`up_down` and `dir_changed` ← 1 on the same edge, unless the event is suppressed (see Configuration).
- `dir_changed` is 0 on every edge where `up_down` does not change. Consecutive presses give separate single-cycle pulses.
- Reset mid-press: all state clears immediately (asynchronous). A button still held after reset deassertion is debounced afresh and produces one toggle.

## Timing
- Press latency: `btn_raw` rises and stays high; the first rising edge that samples it is edge 1.
  - `btn_level` goes to 1 after edge DEBOUNCE_CYCLES + 2.
  - `up_down` toggles and `dir_changed` asserts after edge DEBOUNCE_CYCLES + 3 (edge 7 at the default).
- Release latency: `btn_level` goes to 0 after edge DEBOUNCE_CYCLES + 2 from the first sampled low; the FSM is back in IDLE one edge later.
- The new `up_down` is used by the counter on the edge after it changes. This block never combinationally depends on `count`; all outputs are registered.
- Minimum press-to-press period is 2·(DEBOUNCE_CYCLES + 3) cycles.

## Configuration
- `UPDOWN_AUTO_REVERSE_EN` defined: auto-reverse is compiled in.
  - Auto-reverse condition (evaluated on registered `count`): (`up_down` = 1 and `count` == MAX − 1) or (`up_down` = 0 and `count` == 1). When it holds, `up_down` is flipped and `dir_changed` pulses.
  - The counter sequence becomes …5,6,7,6,5…1,0,1,2… with no wrap.
  - Auto-reverse and a press event on the same edge: exactly one flip, and the press is dropped.
  - A press is suppressed (no flip, no pulse) when `count` == MAX with `up_down` = 0, or `count` == 0 with `up_down` = 1. Either flip would cause a wrap.
- `UPDOWN_AUTO_REVERSE_EN` undefined: only presses change direction; `count` is ignored and the counter wraps naturally, as in 7 → 0 and 0 → 7.

## Test plan
- Reset, then hold `btn_raw` = 0 for 20 cycles → `up_down` = 1, `dir_changed` = 0, `btn_level` = 0 throughout.
- Clean press of 20 cycles at DEBOUNCE_CYCLES = 4 → `up_down` 1 → 0 after edge 7, with `dir_changed` high for exactly that one cycle; the release causes no change.
- Bounce pattern 1,0,1,1,0 then steady 1 → exactly one toggle, timed from the start of the steady run; 3-cycle glitches alone → no toggle.
- With the macro defined and the counter model attached, free-run for 40 cycles → count sequence 0..7..0 with no wrap; `dir_changed` pulses on the edges where `count` goes 6 → 7 and 1 → 0.
- With the macro defined, press landing when `count` = 6 and `up_down` = 1 → a single flip to 0 and one pulse; press landing when `count` = 7 and `up_down` = 0 → suppressed, `up_down` stays 0.
- Assert `rst_n` low mid-debounce while the button is held → outputs return to reset values at once; after release of reset with the button still held → one toggle after edge 7.
